// File: rtl/bsg_mem_sync_read_stream_pkg.sv
// Shared constants and pointer helper for the sync-read streaming buffer.
package bsg_mem_sync_read_stream_pkg;

  localparam int unsigned buf_depth_lp = 3;
  localparam int unsigned ptr_width_lp = 2;

  typedef logic [ptr_width_lp-1:0] ptr_t;
  typedef logic [ptr_width_lp-1:0] count_t;

  // Circular increment over buf_depth_lp entries (2 wraps to 0).
  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == ptr_t'(buf_depth_lp - 1)) ? '0 : ptr_t'(p + 1'b1);
  endfunction

endpackage

// File: rtl/bsg_mem_sync_read_stream_buf.sv
// 3-entry circular buffer holding returned read data until the consumer takes it.
module bsg_mem_sync_read_stream_buf
  import bsg_mem_sync_read_stream_pkg::*;
#(
  parameter int width_p = -1
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic [width_p-1:0] data_i,
  input  logic               capture_i,
  input  logic               yumi_i,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  output count_t             count_o
);

  logic [width_p-1:0] r_mem [buf_depth_lp];
  ptr_t               r_wptr;
  ptr_t               r_rptr;
  count_t             r_count;
  logic               w_yumi;

  assign v_o     = (r_count != '0);
  assign w_yumi  = yumi_i & v_o;
  assign data_o  = r_mem[r_rptr];
  assign count_o = r_count;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (capture_i) r_wptr <= ptr_inc(r_wptr);
      if (w_yumi)    r_rptr <= ptr_inc(r_rptr);
      case ({capture_i, w_yumi})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (capture_i) r_mem[r_wptr] <= data_i;
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (reset_n_i) begin
      assert (!(yumi_i && !v_o))
        else $error("bsg_mem_sync_read_stream: yumi_i asserted while v_o=0");
    end
  end
`endif

endmodule

// File: rtl/bsg_mem_sync_read_stream.sv
// Streams read requests through a sync-read memory port into a 3-entry return buffer.
// Optional write-snoop bypass: define BSG_MEM_SYNC_READ_STREAM_BYPASS_EN.
module bsg_mem_sync_read_stream
  import bsg_mem_sync_read_stream_pkg::*;
#(
  parameter int width_p       = -1,
  parameter int els_p         = -1,
  parameter int addr_width_lp = (els_p > 1) ? $clog2(els_p) : 1
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     v_i,
  input  logic [addr_width_lp-1:0] addr_i,
  output logic                     ready_o,
  output logic                     mem_r_v_o,
  output logic [addr_width_lp-1:0] mem_r_addr_o,
  input  logic [width_p-1:0]       mem_r_data_i,
  input  logic                     mem_w_v_i,
  input  logic [addr_width_lp-1:0] mem_w_addr_i,
  input  logic [width_p-1:0]       mem_w_data_i,
  output logic                     v_o,
  output logic [width_p-1:0]       data_o,
  input  logic                     yumi_i
);

  logic               r_inflight;
  count_t             w_count;
  logic [2:0]         w_pending;
  logic               w_accept;
  logic [width_p-1:0] w_cap_data;

  // Reserve a buffer slot for the read still in flight so capture never overflows.
  assign w_pending    = {1'b0, w_count} + {2'b00, r_inflight};
  assign ready_o      = reset_n_i & (w_pending < 3'(buf_depth_lp));
  assign w_accept     = v_i & ready_o;
  assign mem_r_v_o    = w_accept;
  assign mem_r_addr_o = addr_i;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) r_inflight <= 1'b0;
    else            r_inflight <= w_accept;
  end

`ifdef BSG_MEM_SYNC_READ_STREAM_BYPASS_EN
  logic               r_byp_v;
  logic [width_p-1:0] r_byp_data;

  // Memory is read-first; a same-cycle write to the read address must win.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_byp_v    <= 1'b0;
      r_byp_data <= '0;
    end else begin
      r_byp_v    <= w_accept & mem_w_v_i & (mem_w_addr_i == addr_i);
      r_byp_data <= mem_w_data_i;
    end
  end

  assign w_cap_data = r_byp_v ? r_byp_data : mem_r_data_i;
`else
  logic w_unused;
  assign w_unused   = ^{mem_w_v_i, mem_w_addr_i, mem_w_data_i};
  assign w_cap_data = mem_r_data_i;
`endif

  bsg_mem_sync_read_stream_buf #(
    .width_p(width_p)
  ) u_buf (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .data_i   (w_cap_data),
    .capture_i(r_inflight),
    .yumi_i   (yumi_i),
    .v_o      (v_o),
    .data_o   (data_o),
    .count_o  (w_count)
  );

endmodule

// File: tb/tb_bsg_mem_sync_read_stream.sv
// Randomized self-checking bench for bsg_mem_sync_read_stream with a queue-based reference model.
module tb_bsg_mem_sync_read_stream;

  localparam int W = 8;
  localparam int E = 16;
  localparam int A = 4;

  logic         clk_i = 1'b0;
  logic         reset_n_i = 1'b1;
  logic         v_i = 1'b0;
  logic [A-1:0] addr_i = '0;
  logic         ready_o;
  logic         mem_r_v_o;
  logic [A-1:0] mem_r_addr_o;
  logic [W-1:0] mem_r_data_i = '0;
  logic         mem_w_v_i = 1'b0;
  logic [A-1:0] mem_w_addr_i = '0;
  logic [W-1:0] mem_w_data_i = '0;
  logic         v_o;
  logic [W-1:0] data_o;
  logic         yumi_i = 1'b0;

  always #5 clk_i = ~clk_i;

  bsg_mem_sync_read_stream #(
    .width_p(W),
    .els_p  (E)
  ) dut (
    .clk_i       (clk_i),
    .reset_n_i   (reset_n_i),
    .v_i         (v_i),
    .addr_i      (addr_i),
    .ready_o     (ready_o),
    .mem_r_v_o   (mem_r_v_o),
    .mem_r_addr_o(mem_r_addr_o),
    .mem_r_data_i(mem_r_data_i),
    .mem_w_v_i   (mem_w_v_i),
    .mem_w_addr_i(mem_w_addr_i),
    .mem_w_data_i(mem_w_data_i),
    .v_o         (v_o),
    .data_o      (data_o),
    .yumi_i      (yumi_i)
  );

  int checks = 0;
  int errors = 0;

  // Reference state: memory contents, data waiting for the consumer, the read in flight.
  logic [W-1:0] mem [E];
  logic [W-1:0] exp_q[$];
  logic [W-1:0] popped[$];
  logic         infl_v = 1'b0;
  logic [W-1:0] infl_d = '0;
  logic         last_acc = 1'b0;
  int           acc_count = 0;

  task automatic cycle(input logic v, input logic [A-1:0] a, input logic want,
                       input logic wv, input logic [A-1:0] wa, input logic [W-1:0] wd);
    logic         exp_ready, exp_v, acc, cons;
    logic [W-1:0] rd, rd_mem;
    exp_v     = (exp_q.size() != 0);
    exp_ready = reset_n_i && ((exp_q.size() + int'(infl_v)) < 3);
    v_i = v; addr_i = a; yumi_i = want & exp_v;
    mem_w_v_i = wv; mem_w_addr_i = wa; mem_w_data_i = wd;
    #1;
    checks++;
    if (ready_o !== exp_ready) begin
      errors++; $display("FAIL ready_o got %b expected %b at %0t", ready_o, exp_ready, $time);
    end
    checks++;
    if (v_o !== exp_v) begin
      errors++; $display("FAIL v_o got %b expected %b at %0t", v_o, exp_v, $time);
    end
    if (exp_v) begin
      checks++;
      if (data_o !== exp_q[0]) begin
        errors++; $display("FAIL data_o got %h expected %h at %0t", data_o, exp_q[0], $time);
      end
    end
    checks++;
    if (mem_r_v_o !== (v & exp_ready)) begin
      errors++; $display("FAIL mem_r_v_o got %b expected %b at %0t", mem_r_v_o, v & exp_ready, $time);
    end
    if (v && exp_ready) begin
      checks++;
      if (mem_r_addr_o !== a) begin
        errors++; $display("FAIL mem_r_addr_o got %h expected %h at %0t", mem_r_addr_o, a, $time);
      end
    end
    acc    = v & exp_ready;
    cons   = want & exp_v;
    rd_mem = mem[a];
    rd     = rd_mem;
`ifdef BSG_MEM_SYNC_READ_STREAM_BYPASS_EN
    if (wv && wa == a) rd = wd;
`endif
    @(posedge clk_i);
    if (cons) popped.push_back(exp_q.pop_front());
    if (infl_v) exp_q.push_back(infl_d);
    infl_v   = acc;
    infl_d   = rd;
    if (wv) mem[wa] = wd;
    last_acc = acc;
    if (acc) acc_count++;
    #1;
    mem_r_data_i = acc ? rd_mem : W'($urandom);
  endtask

  task automatic idle(input logic want);
    cycle(1'b0, '0, want, 1'b0, '0, '0);
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || infl_v) && n < 12) begin
      idle(1'b1);
      n++;
    end
    checks++;
    if (exp_q.size() != 0 || infl_v) begin
      errors++; $display("FAIL drain timeout: %0d entries left", exp_q.size());
    end
  endtask

  task automatic do_reset();
    v_i = 1'b1; addr_i = 3; yumi_i = 1'b0; mem_w_v_i = 1'b0;
    reset_n_i = 1'b0;
    #1;
    checks++;
    if (ready_o !== 1'b0 || v_o !== 1'b0 || mem_r_v_o !== 1'b0) begin
      errors++; $display("FAIL reset_outputs got ready=%b v=%b mem_r_v=%b expected 0 0 0", ready_o, v_o, mem_r_v_o);
    end
    repeat (2) @(posedge clk_i);
    #1;
    checks++;
    if (v_o !== 1'b0 || ready_o !== 1'b0) begin
      errors++; $display("FAIL reset_hold got v=%b ready=%b expected 0 0", v_o, ready_o);
    end
    exp_q.delete();
    infl_v = 1'b0;
    reset_n_i = 1'b1;
    #1;
    checks++;
    if (ready_o !== 1'b1) begin
      errors++; $display("FAIL ready_after_reset got %b expected 1", ready_o);
    end
  endtask

  task automatic test_reset();
    do_reset();
    idle(1'b1);
  endtask

  task automatic test_latency();
    drain();
    mem[5] = 8'hA5;
    cycle(1'b1, 4'd5, 1'b1, 1'b0, '0, '0);
    checks++;
    if (!last_acc) begin
      errors++; $display("FAIL latency_accept got 0 expected 1");
    end
    checks++;
    if (v_o !== 1'b0) begin
      errors++; $display("FAIL latency_n1 v_o got %b expected 0", v_o);
    end
    idle(1'b1);
    checks++;
    if (v_o !== 1'b1 || data_o !== 8'hA5) begin
      errors++; $display("FAIL latency_n2 got v=%b data=%h expected v=1 data=a5", v_o, data_o);
    end
    drain();
  endtask

  task automatic test_backpressure();
    int nxt = 1;
    drain();
    popped.delete();
    for (int unsigned i = 1; i <= 4; i++) mem[i] = W'(8'h10 * i + $urandom_range(0, 15));
    for (int k = 0; k < 6; k++) begin
      cycle(1'b1, A'(nxt), 1'b0, 1'b0, '0, '0);
      if (last_acc) nxt++;
    end
    checks++;
    if (nxt != 4) begin
      errors++; $display("FAIL bp_accepts got %0d expected 3", nxt - 1);
    end
    checks++;
    if (ready_o !== 1'b0) begin
      errors++; $display("FAIL bp_ready_low got %b expected 0", ready_o);
    end
    for (int k = 0; k < 20 && nxt <= 4; k++) begin
      cycle(1'b1, A'(nxt), 1'b1, 1'b0, '0, '0);
      if (last_acc) nxt++;
    end
    drain();
    checks++;
    if (popped.size() != 4) begin
      errors++; $display("FAIL bp_count got %0d expected 4", popped.size());
    end else begin
      for (int unsigned i = 0; i < 4; i++) begin
        checks++;
        if (popped[i] !== mem[i+1]) begin
          errors++; $display("FAIL bp_order[%0d] got %h expected %h", i, popped[i], mem[i+1]);
        end
      end
    end
  endtask

  task automatic test_stream();
    int low = 0;
    drain();
    acc_count = 0;
    for (int i = 0; i < 20; i++) begin
      if (i > 0 && ready_o !== 1'b1) low++;
      cycle(1'b1, A'($urandom), 1'b1, 1'b0, '0, '0);
    end
    checks++;
    if (acc_count != 20) begin
      errors++; $display("FAIL stream_accepts got %0d expected 20", acc_count);
    end
    checks++;
    if (low != 0) begin
      errors++; $display("FAIL stream_ready_drops got %0d expected 0", low);
    end
    drain();
  endtask

  task automatic test_bypass();
    logic [W-1:0] expd;
    drain();
    popped.delete();
    mem[7] = 8'h11;
`ifdef BSG_MEM_SYNC_READ_STREAM_BYPASS_EN
    expd = 8'h3C;
`else
    expd = 8'h11;
`endif
    cycle(1'b1, 4'd7, 1'b1, 1'b1, 4'd7, 8'h3C);
    drain();
    checks++;
    if (popped.size() != 1 || popped[0] !== expd) begin
      errors++; $display("FAIL bypass got n=%0d data=%h expected n=1 data=%h",
                         popped.size(), popped.size() ? popped[0] : 8'h00, expd);
    end
  endtask

  task automatic test_reset_inflight();
    drain();
    popped.delete();
    mem[9] = 8'h99;
    mem[2] = 8'h22;
    cycle(1'b1, 4'd9, 1'b1, 1'b0, '0, '0);
    do_reset();
    for (int k = 0; k < 4; k++) idle(1'b1);
    cycle(1'b1, 4'd2, 1'b1, 1'b0, '0, '0);
    drain();
    checks++;
    if (popped.size() != 1 || popped[0] !== 8'h22) begin
      errors++; $display("FAIL reset_inflight got n=%0d data=%h expected n=1 data=22",
                         popped.size(), popped.size() ? popped[0] : 8'h00);
    end
  endtask

  task automatic test_random();
    logic [A-1:0] a;
    for (int k = 0; k < 300; k++) begin
      a = A'($urandom);
      cycle(1'($urandom_range(0, 3) != 0), a, 1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 4) == 0),
            ($urandom_range(0, 1) != 0) ? a : A'($urandom), W'($urandom));
    end
    drain();
  endtask

  initial begin
    for (int unsigned i = 0; i < E; i++) mem[i] = W'($urandom);
    #2;
    test_reset();
    test_latency();
    test_backpressure();
    test_stream();
    test_bypass();
    test_reset_inflight();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bsg_mem_sync_read_stream.md
BSG_MEM_SYNC_READ_STREAM -- requirements
Module: bsg_mem_sync_read_stream

Interface
REQ-001 The block SHALL have parameter width_p, default -1 (must be set), data width in bits, >= 1.
REQ-002 The block SHALL have parameter els_p, default -1 (must be set), number of memory words.
REQ-003 The block SHALL have parameter addr_width_lp, default BSG_SAFE_CLOG2(els_p), address width.
REQ-004 The block SHALL have port clk_i, input, 1, the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port reset_n_i, input, 1, asynchronous active-low reset.
REQ-006 The block SHALL have ports v_i, input, 1 and addr_i, input, addr_width_lp: read request valid and address.
REQ-007 The block SHALL have port ready_o, output, 1, request accepted when v_i & ready_o.
REQ-008 The block SHALL have ports mem_r_v_o, output, 1 and mem_r_addr_o, output, addr_width_lp: drive the sync-read memory port.
REQ-009 The block SHALL have port mem_r_data_i, input, width_p, memory read data, valid the cycle after mem_r_v_o.
REQ-010 The block SHALL have ports mem_w_v_i (1), mem_w_addr_i (addr_width_lp), mem_w_data_i (width_p), all inputs: snoop of the memory write port.
REQ-011 The block SHALL have ports v_o, output, 1 and data_o, output, width_p: returned read data.
REQ-012 The block SHALL have port yumi_i, input, 1, consumer takes data_o this cycle; legal only when v_o=1.

Function
REQ-013 mem_r_v_o SHALL equal v_i & ready_o, and mem_r_addr_o SHALL equal addr_i, combinationally.
REQ-014 A one-bit inflight_r SHALL set on the cycle after an accepted request and clear otherwise.
REQ-015 When inflight_r=1, the returned data SHALL be written into a 3-entry circular buffer at the write pointer at that clock edge.
REQ-016 ready_o SHALL be a function of registered state only: (occupancy + inflight_r) < 3.
REQ-017 v_o SHALL be 1 iff occupancy != 0; data_o SHALL be the entry at the read pointer.
REQ-018 Latency: a request accepted in cycle N SHALL produce v_o=1 no earlier and no later than cycle N+2 when the buffer is empty.
REQ-019 Sustained throughput SHALL be one request per cycle when yumi_i is asserted every cycle v_o=1.
REQ-020 Pointers SHALL wrap 2 -> 0; capture and yumi_i in the same cycle SHALL leave occupancy unchanged.
REQ-021 Returned data SHALL be delivered strictly in request order.
REQ-022 yumi_i while v_o=0 SHALL be ignored, and an assertion SHALL flag it in simulation.

Reset
REQ-023 While reset_n_i=0: occupancy, pointers and inflight_r SHALL be 0, v_o=0, mem_r_v_o=0 and ready_o=0.
REQ-024 ready_o SHALL be 1 in the first cycle after reset_n_i deasserts.
REQ-025 Reset during an in-flight read SHALL discard that read, and no data from it SHALL reach data_o.

Configuration
REQ-026 With macro BSG_MEM_SYNC_READ_STREAM_BYPASS_EN defined, if mem_w_v_i=1 and mem_w_addr_i==addr_i in an accept cycle, the captured entry SHALL be the registered mem_w_data_i instead of mem_r_data_i.
REQ-027 Without the macro, captured data SHALL always be mem_r_data_i, and the mem_w_* inputs SHALL be unused (tied to an unused wire).

Structure
REQ-028 Constant buffer depth (3) and pointer width (2) SHALL live in package bsg_mem_sync_read_stream_pkg.
REQ-029 The 3-entry circular buffer SHALL be sub-module bsg_mem_sync_read_stream_buf (data in, capture enable, yumi, v_o, data_o).

Verification
REQ-030 Reset, then request addr=5 with mem[5]=0xA5 and yumi_i held 1 -> v_o=1 with data_o=0xA5 exactly 2 cycles after acceptance.
REQ-031 Requests 1,2,3,4 back-to-back with yumi_i=0 -> ready_o drops after 3 accepts; after yumi_i, the 4th is accepted and data appears in order 1,2,3,4.
REQ-032 Continuous requests with yumi_i=1 for 20 cycles -> 20 accepts, ready_o never 0 after the first cycle, pointer wrap exercised.
REQ-033 BYPASS_EN: write 0x3C to addr 7 in the cycle a read of 7 is accepted -> data_o=0x3C; without the macro -> data_o=mem_r_data_i.
REQ-034 Assert reset_n_i=0 the cycle after accept -> v_o stays 0 after reset, and the next request returns its own data only.
